baughwooley_pipe_mult: RTL

//  Parametrised, pipelined successor to the 8x8 combinational Baugh-Wooley multiplier.

---
 rtl/baughwooley_pipe_mult_if.sv | 35 +++
 rtl/baughwooley_pipe_mult.sv | 121 ++++++++++++
 2 files changed

// File: rtl/baughwooley_pipe_mult_if.sv
// Stream bundle for baughwooley_pipe_mult: operand beat in, product beat out.
// BWMUL_ACC_EN adds the per-beat acc_en sideband.
interface baughwooley_pipe_mult_if #(
  parameter int unsigned WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               tc;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] s;
`ifdef BWMUL_ACC_EN
  logic               acc_en;

  modport master (
    output in_valid, x, y, tc, acc_en, out_ready,
    input  in_ready, out_valid, s
  );
  modport slave (
    input  in_valid, x, y, tc, acc_en, out_ready,
    output in_ready, out_valid, s
  );
`else
  modport master (
    output in_valid, x, y, tc, out_ready,
    input  in_ready, out_valid, s
  );
  modport slave (
    input  in_valid, x, y, tc, out_ready,
    output in_ready, out_valid, s
  );
`endif
endinterface

// File: rtl/baughwooley_pipe_mult.sv
// Pipelined Baugh-Wooley WIDTH x WIDTH multiplier, signed/unsigned per beat, valid/ready stream.
// Optional BWMUL_ACC_EN: a beat with acc_en=1 adds its product to the previously delivered s.
module baughwooley_pipe_mult #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input logic                   clk,
  input logic                   rst,
  baughwooley_pipe_mult_if.slave io_mul
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned R  = (WIDTH + STAGES - 1) / STAGES;
  localparam logic [PW-1:0] BwConst = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  // Row i of the partial-product array, already shifted into place.
  function automatic logic [PW-1:0] pp_row(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                           logic t, int i);
    logic [WIDTH-1:0] row;
    row = a & {WIDTH{b[i]}};
    if (t) begin
      if (i == int'(WIDTH) - 1) row[WIDTH-2:0] = ~row[WIDTH-2:0];
      else                      row[WIDTH-1]   = ~row[WIDTH-1];
    end
    return PW'(row) << i;
  endfunction

  // Index k holds the inputs seen by stage k; index 0 is the operand port.
  logic             w_en;
  logic             w_vld [STAGES];
  logic             w_tc  [STAGES];
  logic [WIDTH-1:0] w_x   [STAGES];
  logic [WIDTH-1:0] w_y   [STAGES];
  logic [PW-1:0]    w_ps  [STAGES];
`ifdef BWMUL_ACC_EN
  logic             w_acc [STAGES];
`endif

  logic             r_out_vld;
  logic [PW-1:0]    r_s;

  // Global stall: everything holds while the output beat is blocked.
  assign w_en             = !(r_out_vld && !io_mul.out_ready);
  assign io_mul.in_ready  = w_en;
  assign io_mul.out_valid = r_out_vld;
  assign io_mul.s         = r_s;

  assign w_vld[0] = io_mul.in_valid;
  assign w_tc[0]  = io_mul.tc;
  assign w_x[0]   = io_mul.x;
  assign w_y[0]   = io_mul.y;
  assign w_ps[0]  = io_mul.tc ? BwConst : '0;
`ifdef BWMUL_ACC_EN
  assign w_acc[0] = io_mul.acc_en;
`endif

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    logic [PW-1:0] w_sum;

    always_comb begin
      w_sum = w_ps[k];
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (i / int'(R) == k) w_sum = w_sum + pp_row(w_x[k], w_y[k], w_tc[k], i);
      end
    end

    if (k < int'(STAGES) - 1) begin : g_mid
      logic             r_vld;
      logic             r_tc;
      logic [WIDTH-1:0] r_x;
      logic [WIDTH-1:0] r_y;
      logic [PW-1:0]    r_ps;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_vld <= 1'b0;
        end else if (w_en) begin
          r_vld <= w_vld[k];
        end
      end

      always_ff @(posedge clk) begin
        if (w_en) begin
          r_tc <= w_tc[k];
          r_x  <= w_x[k];
          r_y  <= w_y[k];
          r_ps <= w_sum;
        end
      end

      assign w_vld[k+1] = r_vld;
      assign w_tc[k+1]  = r_tc;
      assign w_x[k+1]   = r_x;
      assign w_y[k+1]   = r_y;
      assign w_ps[k+1]  = r_ps;
`ifdef BWMUL_ACC_EN
      logic r_acc;
      always_ff @(posedge clk) begin
        if (w_en) r_acc <= w_acc[k];
      end
      assign w_acc[k+1] = r_acc;
`endif
    end else begin : g_last
      // s only moves when a real beat lands, so bubbles and stalls leave it untouched.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_out_vld <= 1'b0;
          r_s       <= '0;
        end else if (w_en) begin
          r_out_vld <= w_vld[k];
          if (w_vld[k]) begin
`ifdef BWMUL_ACC_EN
            r_s <= w_sum + (w_acc[k] ? r_s : '0);
`else
            r_s <= w_sum;
`endif
          end
        end
      end
    end
  end
endmodule
